// File: rtl/vga_menu_renderer_if.sv
// Order handshake between the menu renderer and the vending controller.
interface vga_menu_renderer_if #(
  parameter int IDX_W = 2
);
  logic             order_valid;
  logic             order_ready;
  logic [IDX_W-1:0] order_slot;

  modport master (output order_valid, output order_slot, input order_ready);
  modport slave  (input order_valid, input order_slot, output order_ready);
endinterface

// File: rtl/vga_menu_renderer.sv
// Product-menu renderer: tiles, greyed-out stock, blinking selection border,
// navigation state and order handshake. Two-stage pixel pipeline on clk_25.
module vga_menu_renderer #(
  parameter int N_SLOTS      = 4,
  parameter int SLOT_X0      = 60,
  parameter int SLOT_PITCH   = 150,
  parameter int SLOT_Y0      = 50,
  parameter int SLOT_W       = 90,
  parameter int SLOT_H       = 105,
  parameter int BORDER_W     = 4,
  parameter int BLINK_FRAMES = 30,
  parameter int COLOR_W      = 10,
  localparam int IDX_W       = $clog2(N_SLOTS)
) (
  input  logic               clk_25,
  input  logic               rst,
  input  logic [9:0]         counter_x_i,
  input  logic [8:0]         counter_y_i,
  input  logic               in_display_i,
  input  logic               hsync_i,
  input  logic               vsync_i,
  input  logic [N_SLOTS-1:0] slot_enable_i,
  input  logic               sel_next_i,
  input  logic               sel_prev_i,
  input  logic               confirm_i,
  output logic [COLOR_W-1:0] vga_r_o,
  output logic [COLOR_W-1:0] vga_g_o,
  output logic [COLOR_W-1:0] vga_b_o,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic [IDX_W-1:0]   sel_index_o,
  vga_menu_renderer_if.master ord_if
);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [COLOR_W-1:0] C_FULL = {COLOR_W{1'b1}};
  localparam logic [COLOR_W-1:0] C_800  = COLOR_W'((800 * ((1 << COLOR_W) - 1)) / 1023);
  localparam logic [COLOR_W-1:0] C_400  = COLOR_W'((400 * ((1 << COLOR_W) - 1)) / 1023);

  typedef enum logic {O_IDLE, O_PEND} ord_t;

  int px, py, cand;
  logic             hit_d, brd_d, hit_q, brd_q, disp_q, found;
  logic [IDX_W-1:0] idx_d, idx_q, sel_d, sel_q, shown_q, slot_d, slot_q;
  logic [COLOR_W-1:0] r_d, g_d, b_d, r_q, g_q, b_q;
  logic hs1_q, hs2_q, vs1_q, vs2_q, blink_q, tick;
  logic [FW-1:0] frame_q;
  ord_t st_d, st_q;

  assign px   = 32'(counter_x_i);
  assign py   = 32'(counter_y_i);
  // vs1_q doubles as the previous vsync sample for edge detection
  assign tick = vs1_q & ~vsync_i;

  // Stage-1 geometry: which tile (if any) the pixel lands in, and whether on its rim
  always_comb begin
    hit_d = 1'b0;
    idx_d = '0;
    brd_d = 1'b0;
    for (int k = 0; k < N_SLOTS; k++) begin
      int lo;
      lo = SLOT_X0 + k * SLOT_PITCH;
      if (px >= lo && px < lo + SLOT_W && py >= SLOT_Y0 && py < SLOT_Y0 + SLOT_H) begin
        hit_d = 1'b1;
        idx_d = IDX_W'(k);
        brd_d = (px - lo < BORDER_W) || (lo + SLOT_W - 1 - px < BORDER_W) ||
                (py - SLOT_Y0 < BORDER_W) || (SLOT_Y0 + SLOT_H - 1 - py < BORDER_W);
      end
    end
  end

  // Stage-1 registers
  always_ff @(posedge clk_25) begin
    if (rst) begin
      hit_q <= 1'b0; idx_q <= '0; brd_q <= 1'b0; disp_q <= 1'b0;
    end else begin
      hit_q <= hit_d; idx_q <= idx_d; brd_q <= brd_d; disp_q <= in_display_i;
    end
  end

  // Stage-2 colour: border of the shown selection beats tile fill
  always_comb begin
    r_d = '0; g_d = '0; b_d = '0;
    if (disp_q && hit_q) begin
      if (brd_q && idx_q == shown_q && blink_q) begin
        r_d = C_FULL; g_d = C_FULL; b_d = C_FULL;
      end else if (slot_enable_i[idx_q]) begin
        r_d = C_FULL; g_d = C_800;
      end else begin
        r_d = C_400; g_d = C_400; b_d = C_400;
      end
    end
  end

  // Stage-2 colour registers and matching sync delay line
  always_ff @(posedge clk_25) begin
    if (rst) begin
      r_q <= '0; g_q <= '0; b_q <= '0;
      hs1_q <= 1'b1; hs2_q <= 1'b1; vs1_q <= 1'b1; vs2_q <= 1'b1;
    end else begin
      r_q <= r_d; g_q <= g_d; b_q <= b_d;
      hs1_q <= hsync_i; hs2_q <= hs1_q; vs1_q <= vsync_i; vs2_q <= vs1_q;
    end
  end

  // Frame-rate state: blink counter/phase and the tear-free shown selection
  always_ff @(posedge clk_25) begin
    if (rst) begin
      frame_q <= '0; blink_q <= 1'b1; shown_q <= '0;
    end else if (tick) begin
      shown_q <= sel_q;
      if (frame_q == FW'(BLINK_FRAMES - 1)) begin
        frame_q <= '0;
        blink_q <= ~blink_q;
      end else begin
        frame_q <= frame_q + 1'b1;
      end
    end
  end

  // Navigation: hop to the nearest enabled slot in the requested direction
  always_comb begin
    sel_d = sel_q;
    found = 1'b0;
    cand  = 0;
    if (sel_next_i != sel_prev_i) begin
      for (int k = 1; k < N_SLOTS; k++) begin
        cand = sel_next_i ? (int'(sel_q) + k) % N_SLOTS
                          : (int'(sel_q) + N_SLOTS - k) % N_SLOTS;
        if (!found && slot_enable_i[IDX_W'(cand)]) begin
          sel_d = IDX_W'(cand);
          found = 1'b1;
        end
      end
    end
  end

  // Order FSM next state: capture pre-navigation selection on a valid confirm
  always_comb begin
    st_d   = st_q;
    slot_d = slot_q;
    case (st_q)
      O_IDLE: if (confirm_i && slot_enable_i[sel_q]) begin
        st_d   = O_PEND;
        slot_d = sel_q;
      end
      O_PEND: if (ord_if.order_ready) st_d = O_IDLE;
      default: st_d = O_IDLE;
    endcase
  end

  // Selection and order state registers
  always_ff @(posedge clk_25) begin
    if (rst) begin
      sel_q <= '0; st_q <= O_IDLE; slot_q <= '0;
    end else begin
      sel_q <= sel_d; st_q <= st_d; slot_q <= slot_d;
    end
  end

  assign vga_r_o            = r_q;
  assign vga_g_o            = g_q;
  assign vga_b_o            = b_q;
  assign hsync_o            = hs2_q;
  assign vsync_o            = vs2_q;
  assign sel_index_o        = sel_q;
  assign ord_if.order_valid = (st_q == O_PEND);
  assign ord_if.order_slot  = slot_q;
endmodule

// File: tb/tb_vga_menu_renderer.sv
// Scoreboard bench for vga_menu_renderer: a frame-level reference model
// predicts every cycle's outputs; a negedge monitor compares them.
module tb_vga_menu_renderer;
  localparam int N = 4, X0 = 60, PITCH = 150, Y0 = 50, W = 90, H = 105, BW = 4, BF = 30;

  logic clk_25 = 1'b0;
  logic rst, in_display, hsync_in, vsync_in, sel_next, sel_prev, confirm;
  logic [9:0] counter_x;
  logic [8:0] counter_y;
  logic [N-1:0] slot_enable;
  logic [9:0] vga_r, vga_g, vga_b;
  logic hsync_out, vsync_out;
  logic [1:0] sel_index;

  always #20 clk_25 = ~clk_25;

  vga_menu_renderer_if #(.IDX_W(2)) oif ();

  vga_menu_renderer dut (
    .clk_25(clk_25), .rst(rst),
    .counter_x_i(counter_x), .counter_y_i(counter_y), .in_display_i(in_display),
    .hsync_i(hsync_in), .vsync_i(vsync_in), .slot_enable_i(slot_enable),
    .sel_next_i(sel_next), .sel_prev_i(sel_prev), .confirm_i(confirm),
    .vga_r_o(vga_r), .vga_g_o(vga_g), .vga_b_o(vga_b),
    .hsync_o(hsync_out), .vsync_o(vsync_out), .sel_index_o(sel_index),
    .ord_if(oif.master)
  );

  typedef struct { int r, g, b, sel, os; bit hs, vs, ov; } exp_t;
  exp_t sbq[$];
  int errors = 0, checks = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int tile_of(int x, int y);
    for (int k = 0; k < N; k++)
      if (x >= X0 + k * PITCH && x < X0 + k * PITCH + W && y >= Y0 && y < Y0 + H) return k;
    return -1;
  endfunction

  function automatic bit on_border(int x, int y, int k);
    int dx, dy;
    dx = x - (X0 + k * PITCH);
    dy = y - Y0;
    return dx < BW || dx >= W - BW || dy < BW || dy >= H - BW;
  endfunction

  function automatic int nav(int sel, int dir, logic [N-1:0] en);
    for (int s = 1; s < N; s++) begin
      int c;
      c = (sel + dir * s + N) % N;
      if (en[c]) return c;
    end
    return sel;
  endfunction

  // reference model state
  int m_sel, m_os, m_frame, m_shown, p1x, p1y;
  bit m_ov, m_blink, p1d, m_hs1, m_vs1;

  initial forever begin
    exp_t e;
    int t, n_sel;
    @(posedge clk_25);
    e.r = 0; e.g = 0; e.b = 0; e.hs = 1; e.vs = 1;
    if (rst) begin
      m_sel = 0; m_os = 0; m_ov = 0; m_frame = 0; m_blink = 1; m_shown = 0;
      p1d = 0; p1x = 0; p1y = 0; m_hs1 = 1; m_vs1 = 1;
    end else begin
      if (p1d) begin
        t = tile_of(p1x, p1y);
        if (t >= 0) begin
          if (on_border(p1x, p1y, t) && t == m_shown && m_blink) begin
            e.r = 1023; e.g = 1023; e.b = 1023;
          end else if (slot_enable[t]) begin
            e.r = 1023; e.g = 800;
          end else begin
            e.r = 400; e.g = 400; e.b = 400;
          end
        end
      end
      e.hs = m_hs1; e.vs = m_vs1;
      n_sel = (sel_next != sel_prev) ? nav(m_sel, sel_next ? 1 : -1, slot_enable) : m_sel;
      if (m_ov) begin
        if (oif.order_ready) m_ov = 0;
      end else if (confirm && slot_enable[m_sel]) begin
        m_ov = 1; m_os = m_sel;
      end
      if (m_vs1 && !vsync_in) begin
        m_shown = m_sel;
        if (m_frame == BF - 1) begin m_frame = 0; m_blink = !m_blink; end
        else m_frame++;
      end
      m_sel = n_sel;
      p1x = counter_x; p1y = counter_y; p1d = in_display;
      m_hs1 = hsync_in; m_vs1 = vsync_in;
    end
    e.sel = m_sel; e.ov = m_ov; e.os = m_os;
    sbq.push_back(e);
  end

  // monitor: one output set per cycle
  initial forever begin
    exp_t e;
    @(negedge clk_25);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("vga_r", int'(vga_r), e.r);
      chk("vga_g", int'(vga_g), e.g);
      chk("vga_b", int'(vga_b), e.b);
      chk("hsync_out", int'(hsync_out), int'(e.hs));
      chk("vsync_out", int'(vsync_out), int'(e.vs));
      chk("sel_index", int'(sel_index), e.sel);
      chk("order_valid", int'(oif.order_valid), int'(e.ov));
      chk("order_slot", int'(oif.order_slot), e.os);
    end
  end

  task automatic step();
    @(posedge clk_25);
    #1;
  endtask

  task automatic pulse_nav(bit nxt);
    if (nxt) sel_next = 1'b1; else sel_prev = 1'b1;
    step();
    sel_next = 1'b0; sel_prev = 1'b0;
  endtask

  initial begin
    rst = 1; counter_x = 0; counter_y = 0; in_display = 0; hsync_in = 1; vsync_in = 1;
    slot_enable = '1; sel_next = 0; sel_prev = 0; confirm = 0; oif.order_ready = 0;
    repeat (3) step();
    rst = 0;

    // pixel inside tile 0 -> yellow two edges later; outside -> black
    counter_x = 100; counter_y = 100; in_display = 1;
    step(); step();
    chk("d_px100_r", int'(vga_r), 1023);
    chk("d_px100_g", int'(vga_g), 800);
    chk("d_px100_b", int'(vga_b), 0);
    counter_x = 10; counter_y = 10;
    step(); step();
    chk("d_px10_r", int'(vga_r), 0);
    chk("d_px10_g", int'(vga_g), 0);

    // skipping a disabled slot both ways
    slot_enable = 4'b1101;
    pulse_nav(1); chk("d_next_skip", int'(sel_index), 2);
    pulse_nav(0); chk("d_prev_skip", int'(sel_index), 0);
    slot_enable = 4'b1111;
    pulse_nav(0); chk("d_prev_wrap", int'(sel_index), 3);
    pulse_nav(1); chk("d_next_wrap", int'(sel_index), 0);
    slot_enable = 4'b0010;
    pulse_nav(1); chk("d_to_only", int'(sel_index), 1);
    pulse_nav(1); chk("d_only_stay", int'(sel_index), 1);

    // order held while not ready; second confirm dropped
    slot_enable = 4'b1111;
    pulse_nav(1);
    confirm = 1; step(); confirm = 0;
    chk("d_ord_valid", int'(oif.order_valid), 1);
    chk("d_ord_slot", int'(oif.order_slot), 2);
    repeat (10) step();
    chk("d_ord_hold", int'(oif.order_valid), 1);
    confirm = 1; sel_next = 1; step(); confirm = 0; sel_next = 0;
    chk("d_ord_2nd", int'(oif.order_slot), 2);
    oif.order_ready = 1; step(); oif.order_ready = 0;
    chk("d_ord_clr", int'(oif.order_valid), 0);

    // randomized frames: short synthetic frame of 40 cycles
    for (int cyc = 0; cyc < 6000; cyc++) begin
      int k;
      vsync_in = (cyc % 40 < 3) ? 1'b0 : 1'b1;
      hsync_in = (cyc % 8 == 0) ? 1'b0 : 1'b1;
      in_display = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 2) == 0) begin
        counter_x = 10'($urandom_range(0, 799));
        counter_y = 9'($urandom_range(0, 511));
      end else begin
        k = $urandom_range(0, N - 1);
        counter_x = 10'(X0 + k * PITCH - 2 + $urandom_range(0, W + 3));
        counter_y = 9'(($urandom_range(0, 1) == 0) ? Y0 - 2 + $urandom_range(0, 8)
                                                   : Y0 + $urandom_range(0, H + 1));
      end
      sel_next = ($urandom_range(0, 15) == 0);
      sel_prev = ($urandom_range(0, 15) == 0);
      confirm  = ($urandom_range(0, 19) == 0);
      oif.order_ready = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) slot_enable = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 2499) == 0);
      step();
    end
    rst = 0; sel_next = 0; sel_prev = 0; confirm = 0;
    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
